// File: rtl/rv_io_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rv_io_arb
//  Purpose  : Round-robin arbiter sharing one IO device port between NREQ
//             CPU-side requesters using the split addr/data IO handshake.
//             One transaction at a time; reads hold the device until their
//             data phase completes, writes finish on the address ack.
//  Revision : 1.0  initial release
// ============================================================================
module rv_io_arb #(
  parameter int RV    = 64,
  parameter int NREQ  = 2,
  parameter int LOG2N = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_addr_req,
  output logic [NREQ-1:0]    req_addr_ack,
  input  logic [NREQ*12-1:0] req_addr,
  input  logic [NREQ-1:0]    req_read,
  input  logic [NREQ*8-1:0]  req_mask,
  input  logic [NREQ*RV-1:0] req_wdata,
  output logic [NREQ-1:0]    req_data_req,
  input  logic [NREQ-1:0]    req_data_ack,
  output logic [RV-1:0]      req_rdata,
  output logic               dev_addr_req,
  input  logic               dev_addr_ack,
  output logic               dev_sel,
  output logic [11:0]        dev_addr,
  output logic               dev_read,
  output logic [7:0]         dev_mask,
  output logic [RV-1:0]      dev_wdata,
  input  logic               dev_data_req,
  output logic               dev_data_ack,
  input  logic [RV-1:0]      dev_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t             state;
  logic [LOG2N-1:0]   grant;
  logic [LOG2N-1:0]   rr_ptr;
  logic [LOG2N-1:0]   next_grant;

  logic               sel_areq;
  logic               sel_read;
  logic               sel_dack;
  logic [11:0]        sel_addr;
  logic [7:0]         sel_mask;
  logic [RV-1:0]      sel_wdata;

  // Round-robin search starting just after the last served requester.
  // Walking from the far end down lets the closest hit win without a break.
  always_comb begin
    int idx;
    idx        = 0;
    next_grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_addr_req[idx]) next_grant = LOG2N'(idx);
    end
  end

  // Fields of the currently granted requester, selected straight from the ports.
  always_comb begin
    int gi;
    gi        = int'(grant);
    sel_areq  = req_addr_req[gi];
    sel_read  = req_read[gi];
    sel_dack  = req_data_ack[gi];
    sel_addr  = req_addr[gi*12 +: 12];
    sel_mask  = req_mask[gi*8 +: 8];
    sel_wdata = req_wdata[gi*RV +: RV];
  end

  // Arbitration FSM: grant in IDLE, address phase in ADDR, read return in RDATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= LOG2N'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req_addr_req) begin
            grant <= next_grant;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (dev_addr_ack) begin
            rr_ptr <= grant;
            state  <= sel_read ? RDATA : IDLE;
          end else if (!sel_areq) begin
            // Requester withdrew without an ack: abandon and pass the turn on.
            rr_ptr <= grant;
            state  <= IDLE;
          end
        end
        RDATA: begin
          if (dev_data_req && sel_dack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering: only the owner sees acks/data valid; IDLE drives nothing.
  always_comb begin
    req_addr_ack = '0;
    req_data_req = '0;
    req_rdata    = dev_rdata;
    dev_addr_req = 1'b0;
    dev_sel      = 1'b0;
    dev_addr     = '0;
    dev_read     = 1'b0;
    dev_mask     = '0;
    dev_wdata    = '0;
    dev_data_ack = 1'b0;
    busy         = (state != IDLE);
    case (state)
      ADDR: begin
        dev_addr_req        = sel_areq;
        dev_sel             = sel_areq;
        dev_addr            = sel_addr;
        dev_read            = sel_read;
        dev_mask            = sel_mask;
        dev_wdata           = sel_wdata;
        req_addr_ack[grant] = dev_addr_ack;
      end
      RDATA: begin
        req_data_req[grant] = dev_data_req;
        dev_data_ack        = sel_dack;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_io_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_io_arb
//  Purpose  : Self-checking bench for rv_io_arb: directed vector table for the
//             protocol scenarios, then random traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv_io_arb;
  localparam int RV    = 64;
  localparam int NREQ  = 2;
  localparam int LOG2N = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_addr_req;
  logic [NREQ-1:0]    req_addr_ack;
  logic [NREQ*12-1:0] req_addr;
  logic [NREQ-1:0]    req_read;
  logic [NREQ*8-1:0]  req_mask;
  logic [NREQ*RV-1:0] req_wdata;
  logic [NREQ-1:0]    req_data_req;
  logic [NREQ-1:0]    req_data_ack;
  logic [RV-1:0]      req_rdata;
  logic               dev_addr_req;
  logic               dev_addr_ack;
  logic               dev_sel;
  logic [11:0]        dev_addr;
  logic               dev_read;
  logic [7:0]         dev_mask;
  logic [RV-1:0]      dev_wdata;
  logic               dev_data_req;
  logic               dev_data_ack;
  logic [RV-1:0]      dev_rdata;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_io_arb #(.RV(RV), .NREQ(NREQ), .LOG2N(LOG2N)) dut (
    .clk(clk), .reset(reset),
    .req_addr_req(req_addr_req), .req_addr_ack(req_addr_ack),
    .req_addr(req_addr), .req_read(req_read), .req_mask(req_mask),
    .req_wdata(req_wdata), .req_data_req(req_data_req),
    .req_data_ack(req_data_ack), .req_rdata(req_rdata),
    .dev_addr_req(dev_addr_req), .dev_addr_ack(dev_addr_ack),
    .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_read(dev_read),
    .dev_mask(dev_mask), .dev_wdata(dev_wdata),
    .dev_data_req(dev_data_req), .dev_data_ack(dev_data_ack),
    .dev_rdata(dev_rdata), .busy(busy)
  );

  typedef struct {
    logic       rst;
    logic [1:0] areq;
    logic [1:0] rd;
    logic       aack;
    logic       dreq;
    logic [1:0] dack;
    logic [7:0] rdata;
    logic       e_areq;
    logic [1:0] e_aack;
    logic [1:0] e_dreq;
    logic       e_dack;
    logic       e_busy;
    logic [11:0] e_addr;
    logic       e_read;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] areq, input logic [1:0] rd,
                              input logic aack, input logic dreq, input logic [1:0] dack,
                              input logic [7:0] rdata, input logic e_areq, input logic [1:0] e_aack,
                              input logic [1:0] e_dreq, input logic e_dack, input logic e_busy,
                              input logic [11:0] e_addr, input logic e_read);
    vec_t v;
    v.rst = rst; v.areq = areq; v.rd = rd; v.aack = aack; v.dreq = dreq; v.dack = dack;
    v.rdata = rdata; v.e_areq = e_areq; v.e_aack = e_aack; v.e_dreq = e_dreq;
    v.e_dack = e_dack; v.e_busy = e_busy; v.e_addr = e_addr; v.e_read = e_read;
    return v;
  endfunction

  // Reference model state: phase 0 = free, 1 = address phase, 2 = read return.
  int m_phase;
  int m_owner;
  int m_last;

  task automatic check_table_row(input int i);
    logic [84:0] act, exp;
    act = {dev_addr_req, dev_sel, req_addr_ack, req_data_req, dev_data_ack, busy,
           dev_addr, dev_read, req_rdata};
    exp = {tbl[i].e_areq, tbl[i].e_areq, tbl[i].e_aack, tbl[i].e_dreq, tbl[i].e_dack,
           tbl[i].e_busy, tbl[i].e_addr, tbl[i].e_read, 56'h0, tbl[i].rdata};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec[%0d]: got %h expected %h", i, act, exp);
    end
  endtask

  task automatic rand_cycle(input int cyc);
    logic [NREQ-1:0] e_aack, e_dreq;
    logic [RV-1:0]   e_wdata;
    logic [11:0]     e_addr;
    logic [7:0]      e_mask;
    logic            e_areq, e_read, e_dack;
    logic [179:0]    act, exp;
    bit              found;
    int              idx;

    reset        = ($urandom_range(63) == 0);
    req_addr_req = NREQ'($urandom);
    req_read     = NREQ'($urandom);
    req_addr     = 24'($urandom);
    req_mask     = 16'($urandom);
    req_wdata    = {$urandom, $urandom, $urandom, $urandom};
    dev_addr_ack = ($urandom_range(2) == 0);
    dev_data_req = 1'($urandom_range(1));
    req_data_ack = NREQ'($urandom);
    dev_rdata    = {$urandom, $urandom};
    #1;

    e_aack = '0; e_dreq = '0; e_wdata = '0; e_addr = '0; e_mask = '0;
    e_areq = 1'b0; e_read = 1'b0; e_dack = 1'b0;
    if (m_phase == 1) begin
      e_areq          = req_addr_req[m_owner];
      e_addr          = req_addr[m_owner*12 +: 12];
      e_read          = req_read[m_owner];
      e_mask          = req_mask[m_owner*8 +: 8];
      e_wdata         = req_wdata[m_owner*RV +: RV];
      e_aack[m_owner] = dev_addr_ack;
    end else if (m_phase == 2) begin
      e_dreq[m_owner] = dev_data_req;
      e_dack          = req_data_ack[m_owner];
    end
    act = {req_addr_ack, req_data_req, req_rdata, dev_addr_req, dev_sel, dev_addr,
           dev_read, dev_mask, dev_wdata, dev_data_ack, busy};
    exp = {e_aack, e_dreq, dev_rdata, e_areq, e_areq, e_addr, e_read, e_mask, e_wdata,
           e_dack, (m_phase != 0)};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL rand cycle %0d: got %h expected %h", cyc, act, exp);
    end

    if (reset) begin
      m_phase = 0;
      m_last  = NREQ - 1;
    end else if (m_phase == 0) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!found && req_addr_req[idx]) begin
          found   = 1;
          m_owner = idx;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (dev_addr_ack) begin
        m_last  = m_owner;
        m_phase = req_read[m_owner] ? 2 : 0;
      end else if (!req_addr_req[m_owner]) begin
        m_last  = m_owner;
        m_phase = 0;
      end
    end else begin
      if (dev_data_req && req_data_ack[m_owner]) m_phase = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req_addr_req = '0; req_read = '0; dev_addr_ack = 1'b0;
    dev_data_req = 1'b0; req_data_ack = '0; dev_rdata = '0;
    req_addr  = {12'h028, 12'h008};
    req_mask  = {8'hFF, 8'h0F};
    req_wdata = {64'h77, 64'h41};

    // single write by req0
    tbl.push_back(mk(0,2'b01,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b01,2'b00,1,0,2'b00,8'h00, 1,2'b01,2'b00,0,1,12'h008,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    // single read by req1, 2-cycle data delay
    tbl.push_back(mk(0,2'b10,2'b10,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b10,2'b10,0,0,2'b00,8'h00, 1,2'b00,2'b00,0,1,12'h028,1));
    tbl.push_back(mk(0,2'b10,2'b10,1,0,2'b00,8'h00, 1,2'b10,2'b00,0,1,12'h028,1));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,1,2'b00,8'h5A, 0,2'b00,2'b10,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,1,2'b01,8'h5A, 0,2'b00,2'b10,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,1,2'b10,8'h5A, 0,2'b00,2'b10,1,1,12'h000,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    // contention: four writes alternate 0,1,0,1
    for (int t = 0; t < 2; t++) begin
      tbl.push_back(mk(0,2'b11,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
      tbl.push_back(mk(0,2'b11,2'b00,1,0,2'b00,8'h00, 1,2'b01,2'b00,0,1,12'h008,0));
      tbl.push_back(mk(0,2'b11,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
      tbl.push_back(mk(0,2'b11,2'b00,1,0,2'b00,8'h00, 1,2'b10,2'b00,0,1,12'h028,0));
    end
    // read lockout: req1 waits while req0 read is in its data phase
    tbl.push_back(mk(0,2'b01,2'b01,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b11,2'b01,1,0,2'b00,8'h00, 1,2'b01,2'b00,0,1,12'h008,1));
    tbl.push_back(mk(0,2'b11,2'b01,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b11,2'b01,1,1,2'b00,8'h33, 0,2'b00,2'b01,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b11,2'b01,0,1,2'b01,8'h33, 0,2'b00,2'b01,1,1,12'h000,0));
    tbl.push_back(mk(0,2'b10,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b10,2'b00,0,0,2'b00,8'h00, 1,2'b00,2'b00,0,1,12'h028,0));
    tbl.push_back(mk(0,2'b10,2'b00,1,0,2'b00,8'h00, 1,2'b10,2'b00,0,1,12'h028,0));
    // mid-operation reset during req0 read data phase
    tbl.push_back(mk(0,2'b01,2'b01,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b01,2'b01,1,0,2'b00,8'h00, 1,2'b01,2'b00,0,1,12'h008,1));
    tbl.push_back(mk(0,2'b00,2'b00,0,1,2'b00,8'h00, 0,2'b00,2'b01,0,1,12'h000,0));
    tbl.push_back(mk(1,2'b00,2'b00,0,1,2'b00,8'h00, 0,2'b00,2'b01,0,1,12'h000,0));
    tbl.push_back(mk(0,2'b11,2'b00,0,1,2'b01,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b11,2'b00,0,0,2'b00,8'h00, 1,2'b00,2'b00,0,1,12'h008,0));
    // protocol violation: req0 withdraws, req1 is served next
    tbl.push_back(mk(0,2'b10,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,1,12'h008,0));
    tbl.push_back(mk(0,2'b10,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));
    tbl.push_back(mk(0,2'b10,2'b00,1,0,2'b00,8'h00, 1,2'b10,2'b00,0,1,12'h028,0));
    tbl.push_back(mk(0,2'b00,2'b00,0,0,2'b00,8'h00, 0,2'b00,2'b00,0,0,12'h000,0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset        = tbl[i].rst;
      req_addr_req = tbl[i].areq;
      req_read     = tbl[i].rd;
      dev_addr_ack = tbl[i].aack;
      dev_data_req = tbl[i].dreq;
      req_data_ack = tbl[i].dack;
      dev_rdata    = {56'h0, tbl[i].rdata};
      #1;
      check_table_row(i);
      @(posedge clk); #1;
    end

    // random traffic against the reference model
    reset = 1'b1; req_addr_req = '0;
    repeat (2) @(posedge clk);
    #1;
    m_phase = 0; m_last = NREQ - 1; m_owner = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_io_arb.md
Name: rv_io_arb

Overview:
- Round-robin arbiter that shares one IO device port (e.g. the UART IO wrapper) between NREQ CPU-side requesters.
- Requesters and device use the same split addr_req/addr_ack + data_req/data_ack IO handshake.
- One transaction is in flight at a time. A read holds the device until its data phase completes; a write completes on addr_ack.
- Sits between the multi-CPU IO switch outputs and a single IO device.

Parameters:
- RV, 64, data width.
- NREQ, 2, number of requesters (2..8).
- LOG2N, 1, grant index width, equal to clog2(NREQ) with minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_addr_req  in  NREQ  per-requester address-phase request
- req_addr_ack  out  NREQ  per-requester address-phase ack
- req_addr  in  NREQ*12  per-requester address; slice i = bits [12i+11:12i]
- req_read  in  NREQ  1 = read, 0 = write
- req_mask  in  NREQ*8  byte masks
- req_wdata  in  NREQ*RV  write data
- req_data_req  out  NREQ  read-data valid, to the owning requester only
- req_data_ack  in  NREQ  read-data ack
- req_rdata  out  RV  read data, broadcast to all requesters; qualified by req_data_req
- dev_addr_req  out  1  device address request
- dev_addr_ack  in  1
- dev_sel  out  1  device select
- dev_addr  out  12
- dev_read  out  1
- dev_mask  out  8
- dev_wdata  out  RV
- dev_data_req  in  1
- dev_data_ack  out  1
- dev_rdata  in  RV
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous):
  - state=IDLE, grant=0, rr_ptr=NREQ-1.
  - All outputs 0, including dev_addr_req, dev_sel, dev_data_ack, all req_* outputs and busy.
  - Applies mid-transaction; the device's own reset is the caller's responsibility.
- FSM states: IDLE, ADDR, RDATA.
- IDLE:
  - If any req_addr_req is set, grant = first index set, searching rr_ptr+1, rr_ptr+2, … modulo NREQ. Move to ADDR next cycle.
  - No device outputs are asserted in IDLE.
  - Latency: requester asserts in cycle 0, dev_addr_req rises in cycle 1.
- ADDR:
  - dev_addr_req = dev_sel = req_addr_req[grant].
  - dev_addr, dev_read, dev_mask and dev_wdata are muxed combinationally from slice [grant]; no field registers.
  - req_addr_ack[grant] = dev_addr_ack (combinational). All other acks are 0.
  - On dev_addr_ack: rr_ptr <= grant. If dev_read=1, go to RDATA; otherwise go to IDLE. dev_addr_req drops the next cycle as the device requires.
  - If req_addr_req[grant] drops without an ack (protocol violation): go to IDLE, rr_ptr <= grant, no ack is issued.
- RDATA:
  - dev_addr_req = 0.
  - req_data_req[grant] = dev_data_req.
  - req_rdata = dev_rdata.
  - dev_data_ack = req_data_ack[grant]; acks from non-granted requesters are ignored.
  - When dev_data_req & dev_data_ack in the same cycle, go to IDLE.
- Outside RDATA: req_data_req = 0 and dev_data_ack = 0. req_rdata = dev_rdata at all times.
- Same cycle ack + new requests: the new grant is evaluated in the following IDLE cycle, so there is a minimum of 1 idle cycle between device transactions.
- Fairness: a requester holding req_addr_req waits at most NREQ-1 transactions.
- Unknown/unused state encodings return to IDLE.

Test Plan:
- Single write: reset, then req0 writes addr=0x008, mask=0x0F, wdata=0x41. Required: dev_addr_req in cycle 1 with dev_addr=0x008 and dev_read=0; req_addr_ack[0] in the same cycle as dev_addr_ack; req_data_req never set; back in IDLE and busy=0 one cycle later.
- Single read: req1 reads addr=0x028; device returns dev_rdata=0x5A with a 2-cycle data delay. Required: req_data_req=2'b10 with req_rdata=0x5A; dev_data_ack follows req_data_ack[1]; FSM returns to IDLE after the handshake.
- Contention (NREQ=2): both requesters request continuously for 4 writes. Required: grant order 0,1,0,1; each transaction has exactly one req_addr_ack pulse, to the right requester.
- Read lockout: req0 read is pending in RDATA while req1 requests. Required: dev_addr_req stays 0 until the req0 data handshake completes; req1 is granted in the next IDLE.
- Mid-operation reset: assert reset in RDATA. Required: on the next cycle all outputs are 0, state=IDLE, and a subsequent req0 request is granted first.
- Protocol violation: in ADDR, req0 drops req_addr_req with no ack. Required: FSM returns to IDLE, no ack is issued, and req1's pending request is granted next.
